counter_btn_ctrl: RTL and testbench
===================================

Name: counter_btn_ctrl

Overview:
Command front-end for the universal N-bit binary counter. Takes raw, asynchronous pushbuttons (up, down, clear, load) and synchronises and debounces each one. Turns button presses into single-cycle counter commands (en/up, syn_clear, load/d), with hold-to-auto-repeat on up/down and optional saturation using the counter's max_tick/min_tick feedback.

Parameters:
N, 8, counter width; width of preset and d.
DB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (>=2).
RPT_DELAY, 25000000, cycles an up/down button must be held after the first step before auto-repeat starts (>=1).
RPT_RATE, 5000000, cycles between auto-repeat steps (>=1).
CW, 26, width of internal debounce/repeat timers; must satisfy 2**CW > max(DB_CYCLES, RPT_DELAY, RPT_RATE).
SAT, 1, 1 = suppress steps past max/min; 0 = allow wrap-around.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
btn_up  in  1  raw up button, active-high, asynchronous to clk.
btn_dn  in  1  raw down button, active-high, asynchronous.
btn_clr  in  1  raw clear button, active-high, asynchronous.
btn_load  in  1  raw load button, active-high, asynchronous.
preset  in  N  value to load; sampled on the cycle the load command is issued.
max_tick  in  1  counter at all-ones (feedback from counter).
min_tick  in  1  counter at zero (feedback from counter).
en  out  1  one-cycle count-enable pulse.
up  out  1  count direction; valid whenever en=1.
syn_clear  out  1  one-cycle synchronous clear pulse.
load  out  1  one-cycle load pulse.
d  out  N  load data; valid whenever load=1.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: en=0, syn_clear=0, load=0, d=0, up=1, all debounced levels=0, all timers=0, FSM=IDLE.
- All outputs are registered.
- Synchroniser: each raw button passes through a 2-flop synchroniser.
- Debouncer (one per button): a timer counts while the synced level differs from the debounced level. It restarts from 0 on any cycle where the two levels match. The debounced level flips on the cycle the timer reaches DB_CYCLES, then the timer clears. Glitches shorter than DB_CYCLES cycles never propagate.
- Edge detect: a rise event is a debounced 0->1 transition. Latency from a clean raw edge to the rise event is 2+DB_CYCLES cycles. The command output appears 1 cycle after the rise event.
- Priority for rise events in the same cycle: clr > load > up/dn. A lower-priority rise event that loses is dropped, not queued.
- Clear: on a clr rise, syn_clear=1 for exactly 1 cycle, and the FSM goes to IDLE (any repeat is aborted). Clear is accepted in every FSM state.
- Load: on a load rise, load=1 for 1 cycle and d<=preset from the same cycle. Load is accepted only in IDLE or WAIT_REL; it does not abort a repeat.
- Step FSM states: IDLE, DELAY, REPEAT, WAIT_REL.
  - IDLE: up rise with dn level 0 -> issue step (up=1), go to DELAY with timer=0. dn rise with up level 0 -> step (up=0), go to DELAY. Rise while the other button's level is 1 -> WAIT_REL, no step.
  - DELAY: the held button releases -> IDLE. The other button's level rises -> WAIT_REL. Timer reaches RPT_DELAY -> step, go to REPEAT with timer=0.
  - REPEAT: timer reaches RPT_RATE -> step, timer=0. Release or other-button conditions as in DELAY.
  - WAIT_REL: stay until both up and dn levels are 0, then IDLE.
- Step: en=1 for 1 cycle and up=direction. up holds its last value when en=0.
- Saturation (SAT=1): suppress the en pulse when stepping up while max_tick=1, or stepping down while min_tick=1. The FSM still advances and the timer still restarts. SAT=0: never suppress.
- At most one of en, syn_clear, load is asserted in any cycle.
- A reset assertion mid-operation clears everything immediately, including a pending pulse. A button still held at reset release must fully debounce again (2+DB_CYCLES cycles) before it generates a rise event.

Test Plan:
1. N=8, DB_CYCLES=4: btn_up high for 3 cycles then low -> no en pulse ever. btn_up held clean -> exactly one en=1, up=1 pulse 7 cycles after the raw edge (2 sync + 4 debounce + 1 register).
2. RPT_DELAY=20, RPT_RATE=5, btn_dn held 50 cycles after debounce -> en (up=0) pulses at step cycles t, t+20, t+25, t+30, t+35, t+40, t+45, then none after release.
3. btn_clr and btn_load rise in the same cycle, preset=8'hA5 -> syn_clear pulse only; no load pulse; d stays 0.
4. IDLE, preset=8'h3C, btn_load pressed -> load=1 for one cycle with d=8'h3C; en=0 and syn_clear=0 throughout.
5. SAT=1, max_tick=1, btn_up held past RPT_DELAY -> en never asserts. SAT=0, same stimulus -> en pulses occur.
6. btn_up held in REPEAT, then btn_dn pressed -> no further en until both are released. Separately, reset asserted mid-REPEAT -> all outputs 0, up=1 the same cycle, no en until a fresh debounced press.

Source files
------------

// File: rtl/counter_btn_ctrl.sv
// ---------------------------------------------------------------------------
// counter_btn_ctrl
// Pushbutton command front-end for the universal N-bit binary counter.
// Each raw button is synchronised, debounced and edge-detected. The resulting
// presses become single-cycle counter commands. Up/down support hold-to-repeat,
// and steps can optionally saturate using the counter's max/min feedback.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_up     raw up button (async, active-high)
//   btn_dn     raw down button (async, active-high)
//   btn_clr    raw clear button (async, active-high)
//   btn_load   raw load button (async, active-high)
//   preset     value to load, sampled in the cycle the load command is issued
//   max_tick   counter is at all-ones
//   min_tick   counter is at zero
//   en         one-cycle count-enable pulse
//   up         count direction, valid while en=1, holds otherwise
//   syn_clear  one-cycle synchronous clear pulse
//   load       one-cycle load pulse
//   d          load data, valid while load=1
//
// Step FSM:
//   state    | meaning
//   IDLE     | no direction button active, waiting for a press
//   DELAY    | first step issued, waiting RPT_DELAY before auto-repeat
//   REPEAT   | auto-repeating one step every RPT_RATE cycles
//   WAIT_REL | conflicting buttons seen, waiting until up and dn both released
// ---------------------------------------------------------------------------
module counter_btn_ctrl #(
  parameter int N         = 8,
  parameter int DB_CYCLES = 500000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000,
  parameter int CW        = 26,
  parameter int SAT       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_dn,
  input  logic         btn_clr,
  input  logic         btn_load,
  input  logic [N-1:0] preset,
  input  logic         max_tick,
  input  logic         min_tick,
  output logic         en,
  output logic         up,
  output logic         syn_clear,
  output logic         load,
  output logic [N-1:0] d
);

  localparam int B_UP   = 0;
  localparam int B_DN   = 1;
  localparam int B_CLR  = 2;
  localparam int B_LOAD = 3;

  // Timers compare against LIMIT-1 so the action lands on the cycle the
  // count would reach LIMIT.
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RPT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_REL} state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1, sync2;
  logic [3:0]    db_lvl, db_prev;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    rise;

  assign raw  = {btn_load, btn_clr, btn_dn, btn_up};
  assign rise = db_lvl & ~db_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_nx;
  logic [CW-1:0] tmr, tmr_nx;
  logic          dir, dir_nx;
  logic          step, step_up;
  logic          en_nx, clr_nx, load_nx;
  logic          up_lvl, dn_lvl, held, other;

  assign up_lvl = db_lvl[B_UP];
  assign dn_lvl = db_lvl[B_DN];
  assign held   = dir ? up_lvl : dn_lvl;
  assign other  = dir ? dn_lvl : up_lvl;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    dir_nx   = dir;
    step     = 1'b0;
    step_up  = dir;
    clr_nx   = 1'b0;
    load_nx  = 1'b0;
    en_nx    = 1'b0;

    if (rise[B_CLR]) begin
      clr_nx   = 1'b1;
      state_nx = IDLE;
      tmr_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise[B_LOAD]) begin
            load_nx = 1'b1;
          end else if (rise[B_UP]) begin
            if (dn_lvl) begin
              state_nx = WAIT_REL;
            end else begin
              step     = 1'b1;
              step_up  = 1'b1;
              dir_nx   = 1'b1;
              state_nx = DELAY;
              tmr_nx   = '0;
            end
          end else if (rise[B_DN]) begin
            if (up_lvl) begin
              state_nx = WAIT_REL;
            end else begin
              step     = 1'b1;
              step_up  = 1'b0;
              dir_nx   = 1'b0;
              state_nx = DELAY;
              tmr_nx   = '0;
            end
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state_nx = IDLE;
          end else if (other) begin
            state_nx = WAIT_REL;
          end else if (tmr == ((state == DELAY) ? DLY_LAST : RATE_LAST)) begin
            step     = 1'b1;
            step_up  = dir;
            state_nx = REPEAT;
            tmr_nx   = '0;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        WAIT_REL: begin
          if (rise[B_LOAD]) load_nx = 1'b1;
          if (!up_lvl && !dn_lvl) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    // A saturated step still advances the FSM; only the pulse is dropped.
    en_nx = step & ~((SAT != 0) & (step_up ? max_tick : min_tick));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      dir       <= 1'b1;
      en        <= 1'b0;
      up        <= 1'b1;
      syn_clear <= 1'b0;
      load      <= 1'b0;
      d         <= '0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      dir       <= dir_nx;
      en        <= en_nx;
      syn_clear <= clr_nx;
      load      <= load_nx;
      if (en_nx)   up <= step_up;
      if (load_nx) d  <= preset;
    end
  end

endmodule

// File: tb/tb_counter_btn_ctrl.sv
module tb_counter_btn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_dn, btn_clr, btn_load;
  logic [7:0] preset;
  logic       max_tick, min_tick;
  logic       en, up, syn_clear, load;
  logic [7:0] d;
  logic       en_ns, up_ns, syn_clear_ns, load_ns;
  logic [7:0] d_ns;

  always #5 clk = ~clk;

  counter_btn_ctrl #(.N(8), .DB_CYCLES(4), .RPT_DELAY(20), .RPT_RATE(5), .CW(8), .SAT(1)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .btn_load(btn_load), .preset(preset), .max_tick(max_tick), .min_tick(min_tick),
    .en(en), .up(up), .syn_clear(syn_clear), .load(load), .d(d));

  counter_btn_ctrl #(.N(8), .DB_CYCLES(4), .RPT_DELAY(20), .RPT_RATE(5), .CW(8), .SAT(0)) dut_ns (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .btn_load(btn_load), .preset(preset), .max_tick(max_tick), .min_tick(min_tick),
    .en(en_ns), .up(up_ns), .syn_clear(syn_clear_ns), .load(load_ns), .d(d_ns));

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int excl_viol = 0;

  int         en_q[$];
  logic       en_up_q[$];
  int         en_ns_q[$];
  int         clr_q[$];
  int         load_q[$];
  logic [7:0] load_d_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (en) begin
      en_q.push_back(cyc);
      en_up_q.push_back(up);
    end
    if (en_ns) en_ns_q.push_back(cyc);
    if (syn_clear) clr_q.push_back(cyc);
    if (load) begin
      load_q.push_back(cyc);
      load_d_q.push_back(d);
    end
    if ((int'(en) + int'(syn_clear) + int'(load)) > 1) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_logs();
    en_q.delete();
    en_up_q.delete();
    en_ns_q.delete();
    clr_q.delete();
    load_q.delete();
    load_d_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base, base2, cnt_late;
  int t2_exp[7] = '{7, 27, 32, 37, 42, 47, 52};
  int t5_exp[5] = '{7, 27, 32, 37, 42};

  initial begin
    reset = 1'b1;
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0; btn_load = 1'b0;
    preset = 8'h00; max_tick = 1'b0; min_tick = 1'b0;
    wait_cyc(3);
    check("rst_en", en, 1'b0);
    check("rst_syn_clear", syn_clear, 1'b0);
    check("rst_load", load, 1'b0);
    check("rst_d", d, 8'h00);
    check("rst_up", up, 1'b1);
    reset = 1'b0;
    wait_cyc(10);

    // short glitch on up: shorter than the debounce window
    clear_logs();
    btn_up = 1'b1;
    wait_cyc(3);
    btn_up = 1'b0;
    wait_cyc(20);
    check("glitch_no_en", en_q.size(), 0);

    // clean single press, released before auto-repeat
    clear_logs();
    base = cyc;
    btn_up = 1'b1;
    wait_cyc(15);
    btn_up = 1'b0;
    wait_cyc(15);
    check("press_en_count", en_q.size(), 1);
    if (en_q.size() == 1) begin
      check("press_en_cycle", en_q[0], base + 7);
      check("press_en_up", en_up_q[0], 1'b1);
    end

    // hold down through delay and repeat
    clear_logs();
    base = cyc;
    btn_dn = 1'b1;
    wait_cyc(48);
    btn_dn = 1'b0;
    wait_cyc(20);
    check("repeat_en_count", en_q.size(), 7);
    if (en_q.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("repeat_cycle%0d", i), en_q[i], base + t2_exp[i]);
        check($sformatf("repeat_up%0d", i), en_up_q[i], 1'b0);
      end
    end
    check("repeat_up_hold", up, 1'b0);

    // clear and load in the same cycle: clear wins
    clear_logs();
    preset = 8'hA5;
    base = cyc;
    btn_clr = 1'b1;
    btn_load = 1'b1;
    wait_cyc(12);
    btn_clr = 1'b0;
    btn_load = 1'b0;
    wait_cyc(12);
    check("clrload_clr_count", clr_q.size(), 1);
    if (clr_q.size() == 1) check("clrload_clr_cycle", clr_q[0], base + 7);
    check("clrload_load_count", load_q.size(), 0);
    check("clrload_d", d, 8'h00);

    // plain load from IDLE
    clear_logs();
    preset = 8'h3C;
    base = cyc;
    btn_load = 1'b1;
    wait_cyc(12);
    btn_load = 1'b0;
    preset = 8'h00;
    wait_cyc(12);
    check("load_count", load_q.size(), 1);
    if (load_q.size() == 1) begin
      check("load_cycle", load_q[0], base + 7);
      check("load_d", load_d_q[0], 8'h3C);
    end
    check("load_no_en", en_q.size(), 0);
    check("load_no_clr", clr_q.size(), 0);
    check("load_d_hold", d, 8'h3C);

    // saturation at max: SAT=1 suppresses, SAT=0 keeps stepping
    clear_logs();
    max_tick = 1'b1;
    base = cyc;
    btn_up = 1'b1;
    wait_cyc(40);
    btn_up = 1'b0;
    wait_cyc(15);
    max_tick = 1'b0;
    check("sat_no_en", en_q.size(), 0);
    check("nosat_en_count", en_ns_q.size(), 5);
    if (en_ns_q.size() == 5) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("nosat_cycle%0d", i), en_ns_q[i], base + t5_exp[i]);
    end

    // saturation at min on a down step
    clear_logs();
    min_tick = 1'b1;
    btn_dn = 1'b1;
    wait_cyc(15);
    btn_dn = 1'b0;
    wait_cyc(15);
    min_tick = 1'b0;
    check("sat_min_no_en", en_q.size(), 0);
    check("nosat_min_en", en_ns_q.size(), 1);

    // other button pressed during REPEAT: no more steps until both released
    clear_logs();
    base = cyc;
    btn_up = 1'b1;
    wait_cyc(30);
    btn_dn = 1'b1;
    wait_cyc(20);
    check("conflict_en_count", en_q.size(), 3);
    if (en_q.size() == 3) check("conflict_last", en_q[2], base + 32);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_cyc(15);
    check("conflict_after_rel", en_q.size(), 3);

    // reset in the middle of REPEAT, button still held across release
    clear_logs();
    base = cyc;
    btn_dn = 1'b1;
    wait_cyc(31);
    check("pre_rst_up", up, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_en", en, 1'b0);
    check("midrst_up", up, 1'b1);
    check("midrst_syn_clear", syn_clear, 1'b0);
    check("midrst_load", load, 1'b0);
    check("midrst_d", d, 8'h00);
    wait_cyc(3);
    clear_logs();
    base2 = cyc;
    reset = 1'b0;
    wait_cyc(20);
    btn_dn = 1'b0;
    wait_cyc(15);
    check("postrst_en_count", en_q.size(), 1);
    if (en_q.size() == 1) begin
      check("postrst_en_cycle", en_q[0], base2 + 7);
      check("postrst_en_up", en_up_q[0], 1'b0);
    end

    cnt_late = excl_viol;
    check("exclusive_pulses", cnt_late, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
